rv32i_prefetch_fetch_stage: RTL

RV32I_PREFETCH_FETCH_STAGE -- requirements
Module: rv32i_prefetch_fetch_stage

---
 rtl/rv32i_prefetch_fetch_stage.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_prefetch_fetch_stage.sv
// ---------------------------------------------------------------------------
// rv32i_prefetch_fetch_stage
//
// Instruction prefetcher for an RV32I front end. The block issues
// word-aligned read requests from a fetch PC (fpc). It tracks the PC of every
// live request in an in-order pending-PC FIFO. Returned words go into a small
// fetch queue, and the queue head is presented to decode.
//
// Queue credits:
//   A request is only issued when
//     live outstanding requests + queued entries < QUEUE_DEPTH.
//   This guarantees that every live response has a queue slot.
//
// Redirects:
//   A redirect flushes the queue and the pending-PC FIFO. Responses still in
//   flight at that point are counted into a discard counter and dropped when
//   they arrive. They no longer count as live outstanding requests, so
//   fetching at the new target starts on the next cycle.
//
// Faults:
//   An access-fault response moves the block into FAULT_HOLD. In FAULT_HOLD
//   no new requests are issued and the remaining live responses are dropped,
//   until the next redirect.
//
// Ports
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_redirect_valid/pc redirect request and target PC (bits [1:0] ignored)
//   o_mem_req_valid/addr, i_mem_req_ready   read request handshake
//   i_mem_rsp_valid/data/err                in-order read responses
//   o_fetch_valid/pc/instr/fault, i_decode_ready   queue head to decode
// ---------------------------------------------------------------------------
module rv32i_prefetch_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  input  logic        i_mem_rsp_err,
  output logic        o_fetch_valid,
  input  logic        i_decode_ready,
  output logic [31:0] o_fetch_pc,
  output logic [31:0] o_fetch_instr,
  output logic        o_fetch_fault
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // Discard counter is wider than MAX_OUTSTANDING because repeated redirects
  // against a slow memory can stack up dropped responses.
  localparam int DW = 8;

  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]   NOP_C   = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_FAULT_HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [DW-1:0]   discard_q, discard_d;
  logic [QW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CW-1:0]   q_cnt_q, q_cnt_d;
  logic [PW-1:0]   pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;

  logic [31:0]     q_pc_q    [QUEUE_DEPTH];
  logic [31:0]     q_instr_q [QUEUE_DEPTH];
  logic            q_err_q   [QUEUE_DEPTH];
  logic [31:0]     pf_pc_q   [MAX_OUTSTANDING];

  logic            req_valid_s;
  logic            req_fire_s;
  logic            rsp_discard_s;
  logic            rsp_live_s;
  logic            push_s;
  logic            head_present_s;
  logic            fetch_valid_s;
  logic            pop_s;
  logic            unused_redirect_lsb_s;

  // Pending-PC FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(MAX_OUTSTANDING - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign unused_redirect_lsb_s = ^i_redirect_pc[1:0];

  // The credit check counts only live requests. Responses that will be
  // discarded never occupy a queue slot.
  assign req_valid_s = !i_rst && (state_q == ST_RUN) && !i_redirect_valid &&
                       (outstanding_q < MAXO_C) &&
                       (({1'b0, outstanding_q} + {1'b0, q_cnt_q}) < {1'b0, DEPTH_C});
  assign req_fire_s  = req_valid_s && i_mem_req_ready;

  // A response belongs to a discarded request while the discard counter is
  // nonzero. Otherwise it matches the head of the pending-PC FIFO.
  assign rsp_discard_s = i_mem_rsp_valid && (discard_q != {DW{1'b0}});
  assign rsp_live_s    = i_mem_rsp_valid && (discard_q == {DW{1'b0}});
  assign push_s        = !i_rst && rsp_live_s && (state_q == ST_RUN) && !i_redirect_valid;

  assign head_present_s = !i_rst && (q_cnt_q != {CW{1'b0}});
  assign fetch_valid_s  = head_present_s && !i_redirect_valid;
  assign pop_s          = fetch_valid_s && i_decode_ready;

  assign o_mem_req_valid = req_valid_s;
  assign o_mem_req_addr  = fpc_q;
  assign o_fetch_valid   = fetch_valid_s;
  assign o_fetch_pc      = head_present_s ? q_pc_q[q_rd_q] : 32'h0000_0000;
  assign o_fetch_fault   = head_present_s ? q_err_q[q_rd_q] : 1'b0;
  assign o_fetch_instr   = (head_present_s && !q_err_q[q_rd_q]) ? q_instr_q[q_rd_q] : NOP_C;

  // Next-state logic: a redirect overrides every other update in its cycle.
  always_comb begin
    state_d       = state_q;
    fpc_d         = fpc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    q_wr_d        = q_wr_q;
    q_rd_d        = q_rd_q;
    q_cnt_d       = q_cnt_q;
    pf_wr_d       = pf_wr_q;
    pf_rd_d       = pf_rd_q;

    if (i_redirect_valid) begin
      state_d       = ST_RUN;
      fpc_d         = {i_redirect_pc[31:2], 2'b00};
      outstanding_d = {CW{1'b0}};
      // Everything still in flight, minus the response dropped this cycle.
      discard_d     = discard_q + DW'(outstanding_q) - DW'(i_mem_rsp_valid);
      q_wr_d        = {QW{1'b0}};
      q_rd_d        = {QW{1'b0}};
      q_cnt_d       = {CW{1'b0}};
      pf_wr_d       = {PW{1'b0}};
      pf_rd_d       = {PW{1'b0}};
    end else begin
      if (req_fire_s) begin
        fpc_d   = fpc_q + 32'd4;
        pf_wr_d = pf_inc(pf_wr_q);
      end else begin
        fpc_d   = fpc_q;
        pf_wr_d = pf_wr_q;
      end

      if (rsp_live_s) begin
        pf_rd_d = pf_inc(pf_rd_q);
      end else begin
        pf_rd_d = pf_rd_q;
      end

      case ({req_fire_s, rsp_live_s})
        2'b10:   outstanding_d = outstanding_q + CW'(1);
        2'b01:   outstanding_d = outstanding_q - CW'(1);
        default: outstanding_d = outstanding_q;
      endcase

      if (rsp_discard_s) begin
        discard_d = discard_q - DW'(1);
      end else begin
        discard_d = discard_q;
      end

      if (push_s && i_mem_rsp_err) begin
        state_d = ST_FAULT_HOLD;
      end else begin
        state_d = state_q;
      end

      q_wr_d = push_s ? (q_wr_q + QW'(1)) : q_wr_q;
      q_rd_d = pop_s  ? (q_rd_q + QW'(1)) : q_rd_q;
      case ({push_s, pop_s})
        2'b10:   q_cnt_d = q_cnt_q + CW'(1);
        2'b01:   q_cnt_d = q_cnt_q - CW'(1);
        default: q_cnt_d = q_cnt_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_RUN;
      fpc_q         <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {DW{1'b0}};
      q_wr_q        <= {QW{1'b0}};
      q_rd_q        <= {QW{1'b0}};
      q_cnt_q       <= {CW{1'b0}};
      pf_wr_q       <= {PW{1'b0}};
      pf_rd_q       <= {PW{1'b0}};
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
      q_cnt_q       <= q_cnt_d;
      pf_wr_q       <= pf_wr_d;
      pf_rd_q       <= pf_rd_d;
    end
  end

  // Fetch-queue storage. A response is tagged with the PC of its request.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      q_pc_q[q_wr_q]    <= pf_pc_q[pf_rd_q];
      q_instr_q[q_wr_q] <= i_mem_rsp_data;
      q_err_q[q_wr_q]   <= i_mem_rsp_err;
    end
  end

  // Pending-PC storage: one entry per accepted, still-live request.
  always_ff @(posedge i_clk) begin
    if (req_fire_s) begin
      pf_pc_q[pf_wr_q] <= fpc_q;
    end
  end

endmodule
